// File: rtl/prbs_led_status.sv
// Board LED status for PRBS link test: link/test/error/fail indicators plus a
// saturating counter of PRBS error cycles that were not injected on purpose.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | link not up; led[0] blinks slow
// LINKED   | link up, checker idle; led[0] solid
// CHECKING | checker running, no pass yet; led[1] blinks fast
// PASS     | self-test passed, no counted error since last clear; led[1] solid
// FAIL     | counted error seen since last clear; led[3] solid
module prbs_led_status #(
    parameter int BLINK_DIV      = 25000000,
    parameter int STRETCH_CYCLES = 2500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        alldone,
    input  logic [2:0]  rx_prbs_mode,
    input  logic        error_inject,
    input  logic        prbscntreset,
    input  logic        rx_prbs_err,
    input  logic        prbs_test_pass,
    output logic [3:0]  led,
    output logic [15:0] err_count
);

    localparam int PW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam int SW = $clog2(STRETCH_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_MAX    = PW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LINKED   = 3'd1,
        ST_CHECKING = 3'd2,
        ST_PASS     = 3'd3,
        ST_FAIL     = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_presc;
    logic [2:0]      r_phase;
    logic [SW-1:0]   r_stretch;
    logic [15:0]     r_err_count;

    logic            w_tick;
    logic            w_slow;
    logic            w_fast;
    logic            w_mode_active;
    logic            w_counted_err;
    logic [3:0]      w_led;

    assign w_tick        = (r_presc == PRESC_MAX);
    assign w_slow        = r_phase[2];
    assign w_fast        = r_phase[0];
    assign w_mode_active = |rx_prbs_mode;
    assign w_counted_err = rx_prbs_err && !error_inject &&
                           ((r_state == ST_PASS) || (r_state == ST_FAIL));

    // Blink timebase: prescaler wraps at BLINK_DIV-1, phase steps on each wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_phase <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_phase <= r_phase + 3'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!alldone) begin
            w_state_nxt = ST_IDLE;
        end else if (!w_mode_active &&
                     ((r_state == ST_CHECKING) || (r_state == ST_PASS) ||
                      (r_state == ST_FAIL))) begin
            w_state_nxt = ST_LINKED;
        end else begin
            case (r_state)
                ST_IDLE:     w_state_nxt = ST_LINKED;
                ST_LINKED:   if (w_mode_active)  w_state_nxt = ST_CHECKING;
                ST_CHECKING: if (prbs_test_pass) w_state_nxt = ST_PASS;
                ST_PASS:     if (w_counted_err)  w_state_nxt = ST_FAIL;
                ST_FAIL:     if (prbscntreset)   w_state_nxt = ST_PASS;
                default:     w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Clear beats a same-cycle increment; the count survives link drops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_err_count <= '0;
        end else if (prbscntreset) begin
            r_err_count <= '0;
        end else if (w_counted_err && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stretch <= '0;
        end else if (prbscntreset) begin
            r_stretch <= '0;
        end else if (w_counted_err) begin
            r_stretch <= STRETCH_LOAD;
        end else if (r_stretch != '0) begin
            r_stretch <= r_stretch - SW'(1);
        end
    end

    // Pure decode of registered state so a state change shows on the same edge.
    always_comb begin
        w_led    = 4'b0000;
        w_led[2] = (r_stretch != '0);
        case (r_state)
            ST_IDLE: begin
                w_led[0] = w_slow;
            end
            ST_LINKED: begin
                w_led[0] = 1'b1;
            end
            ST_CHECKING: begin
                w_led[0] = 1'b1;
                w_led[1] = w_fast;
            end
            ST_PASS: begin
                w_led[0] = 1'b1;
                w_led[1] = 1'b1;
            end
            ST_FAIL: begin
                w_led[0] = 1'b1;
                w_led[3] = 1'b1;
            end
            default: begin
                w_led[0] = 1'b0;
            end
        endcase
    end

    assign led       = w_led;
    assign err_count = r_err_count;

endmodule

// File: doc/prbs_led_status.md
PRBS_LED_STATUS -- requirements
Module: prbs_led_status

Interface
REQ-001 Parameter BLINK_DIV, default 25000000: clk cycles per blink-phase tick (at least 2).
REQ-002 Parameter STRETCH_CYCLES, default 2500000: led[2] hold time per counted error (at least 1).
REQ-003 clk  input  1  single clock; every flop in the block is clocked by its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 alldone  input  1  link bring-up complete.
REQ-006 rx_prbs_mode  input  3  checker mode from the PRBS FSM; non-zero means the checker is running.
REQ-007 error_inject  input  1  error injection active; errors seen while it is high are not counted.
REQ-008 prbscntreset  input  1  clears error counter and fail status.
REQ-009 rx_prbs_err  input  1  per-cycle checker error flag.
REQ-010 prbs_test_pass  input  1  sticky self-test pass flag from the PRBS FSM.
REQ-011 led  output  4  board LEDs: [0] link, [1] test, [2] error pulse, [3] fail.
REQ-012 err_count  output  16  saturating count of counted error cycles.

Function
REQ-013 All inputs are synchronous to clk; the block does no input synchronisation.
REQ-014 Prescaler counts 0 to BLINK_DIV-1 and wraps; on wrap it pulses tick; a 3-bit phase counter increments on tick and wraps 7 to 0.
REQ-015 Blink signals: slow = phase[2]; fast = phase[0].
REQ-016 FSM states: IDLE, LINKED, CHECKING, PASS, FAIL.
REQ-017 Transition priority, in order:
- alldone=0 forces IDLE from any state.
- Else rx_prbs_mode=0 forces LINKED from CHECKING, PASS or FAIL.
REQ-018 Normal transitions:
- IDLE to LINKED when alldone=1.
- LINKED to CHECKING when rx_prbs_mode is non-zero.
- CHECKING to PASS when prbs_test_pass=1.
REQ-019 Counted error = rx_prbs_err=1 AND error_inject=0 AND state is PASS or FAIL.
REQ-020 PASS to FAIL on a counted error, taking effect the next cycle.
REQ-021 FAIL to PASS when prbscntreset=1 and no higher-priority transition applies.
REQ-022 err_count update rules:
- Increments by 1 per counted-error cycle.
- Saturates at 0xFFFF and never wraps.
- Cleared to 0 by prbscntreset; clear wins over a same-cycle increment.
- Not cleared by an alldone drop or an rx_prbs_mode change.
REQ-023 Stretch counter: a counted error loads STRETCH_CYCLES (retriggerable); otherwise it decrements to 0 and holds; prbscntreset clears it to 0 with priority over a load.
REQ-024 led[0] = slow in IDLE; 1 in all other states.
REQ-025 led[1] = fast in CHECKING; 1 in PASS; 0 in IDLE, LINKED and FAIL.
REQ-026 led[2] = 1 while the stretch counter is non-zero.
REQ-027 led[3] = 1 only in FAIL.
REQ-028 led and err_count decode only from registered state and counters.
- No combinational path from any input to any output.
- A state change is visible on led in the same cycle the state register updates.

Reset
REQ-029 reset_n=0 sampled at a clk edge sets:
- state = IDLE;
- prescaler, phase, stretch counter and err_count = 0;
- led = 4'b0000.
REQ-030 reset_n takes priority over every other input, including prbscntreset.
REQ-031 Reset asserted mid-operation (for example in FAIL with err_count non-zero) returns all state to the REQ-029 values on that edge.
REQ-032 The phase counter restarts from 0 on reset release.

Verification (BLINK_DIV=4, STRETCH_CYCLES=8)
REQ-033 Reset: reset_n=0 for 3 cycles, then release with alldone=0 -> led=0000 during reset; led[0] first rises after 16 cycles and toggles every 16 cycles thereafter.
REQ-034 Bring-up sequence:
- alldone=1 -> LINKED, led=0001.
- rx_prbs_mode=100 -> CHECKING, led[1] toggles every 4 cycles.
- prbs_test_pass=1 -> PASS, led=0011.
REQ-035 Injected errors ignored: in PASS with error_inject=1, rx_prbs_err=1 for 10 cycles -> err_count=0, led[3]=0, led[2]=0.
REQ-036 Counted errors and recovery:
- error_inject=0, rx_prbs_err=1 for 3 cycles -> err_count=3, FAIL, led=1101.
- led[2] falls 8 cycles after the last error.
- prbscntreset pulse -> err_count=0, PASS.
REQ-037 Saturation and simultaneous events:
- 65540 counted-error cycles -> err_count=0xFFFF.
- prbscntreset together with rx_prbs_err in the same cycle -> err_count=0, led[2]=0.
REQ-038 Priority: alldone drops in FAIL with err_count=5 -> IDLE next cycle, led[3]=0, led[0] blinking, err_count stays 5.
